// File: rtl/window_filter_pkg.sv
// Shared definitions for the window statistics filter: mode encodings and
// elaboration-time helpers for tree depth, reciprocal and centre position.
package window_filter_pkg;

  typedef enum logic [1:0] {
    MODE_MEAN   = 2'd0,
    MODE_MIN    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_CENTRE = 2'd3
  } mode_e;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // ceil(2**frac / n), used to turn the division by N into a multiply.
  function automatic logic [63:0] recip(input int n, input int frac);
    logic [63:0] num;
    num = 64'd1 << frac;
    return (num + 64'(n) - 64'd1) / 64'(n);
  endfunction

  // Row-major index of the centre pixel; for even WIN this picks the
  // lower-right pixel of the central 2x2 group.
  function automatic int centre_index(input int win);
    return (win / 2) * win + win / 2;
  endfunction

  // Number of elements left after lvl pairwise tree levels starting from n.
  function automatic int lvl_cnt(input int n, input int lvl);
    return (n + (32'sd1 <<< lvl) - 32'sd1) >>> lvl;
  endfunction

endpackage

// File: rtl/window_stat_filter_reduce_stage.sv
// One registered level of the sum/min/max reduction trees. Adjacent pairs
// are combined; an odd trailing element is carried through unchanged.
module reduce_stage #(
  parameter int N_IN  = 9,
  parameter int W     = 8,
  parameter int SW    = 12,
  parameter int N_OUT = (N_IN + 1) / 2
) (
  input  logic                clk,
  input  logic                en,
  input  logic [N_IN*SW-1:0]  sum_i,
  input  logic [N_IN*W-1:0]   min_i,
  input  logic [N_IN*W-1:0]   max_i,
  output logic [N_OUT*SW-1:0] sum_o,
  output logic [N_OUT*W-1:0]  min_o,
  output logic [N_OUT*W-1:0]  max_o
);

  logic [N_OUT*SW-1:0] sum_d, sum_q;
  logic [N_OUT*W-1:0]  min_d, min_q;
  logic [N_OUT*W-1:0]  max_d, max_q;

  // Partner index of output i; clamped onto itself for the odd tail so no
  // select ever leaves the input vector.
  function automatic int hi_idx(input int i);
    return (2 * i + 1 < N_IN) ? (2 * i + 1) : (2 * i);
  endfunction

  // Combine element pairs when the pipeline advances, otherwise hold.
  always_comb begin
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    if (en) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (2 * i + 1 < N_IN) begin
          sum_d[i*SW +: SW] = sum_i[(2*i)*SW +: SW] + sum_i[hi_idx(i)*SW +: SW];
          min_d[i*W +: W]   = (min_i[(2*i)*W +: W] < min_i[hi_idx(i)*W +: W]) ?
                              min_i[(2*i)*W +: W] : min_i[hi_idx(i)*W +: W];
          max_d[i*W +: W]   = (max_i[(2*i)*W +: W] > max_i[hi_idx(i)*W +: W]) ?
                              max_i[(2*i)*W +: W] : max_i[hi_idx(i)*W +: W];
        end else begin
          sum_d[i*SW +: SW] = sum_i[(2*i)*SW +: SW];
          min_d[i*W +: W]   = min_i[(2*i)*W +: W];
          max_d[i*W +: W]   = max_i[(2*i)*W +: W];
        end
      end
    end else begin
      sum_d = sum_q;
      min_d = min_q;
      max_d = max_q;
    end
  end

  // Level registers; pure data, validity is tracked by the parent.
  always_ff @(posedge clk) begin
    sum_q <= sum_d;
    min_q <= min_d;
    max_q <= max_d;
  end

  assign sum_o = sum_q;
  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/window_stat_filter.sv
// WIN x WIN window reducer: per-beat rounded mean, minimum, maximum or
// centre bypass, fully pipelined with a single global stall enable.
module window_stat_filter
  import window_filter_pkg::*;
#(
  parameter int WIN     = 3,
  parameter int COLOR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COLOR_W*WIN*WIN-1:0] in_data,
  input  logic [1:0]                 in_mode,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLOR_W-1:0]         out_data,
  output logic                       out_last
);

  localparam int N       = WIN * WIN;
  localparam int NLOG    = clog2(N);
  localparam int SUM_W   = COLOR_W + NLOG;
  localparam int FRAC    = SUM_W + 1 + NLOG;
  localparam int RECIP_W = FRAC + 1;
  localparam int PROD_W  = SUM_W + 1 + RECIP_W;
  localparam int CTR     = centre_index(WIN);
  localparam logic [RECIP_W-1:0] RECIP_V = RECIP_W'(recip(N, FRAC));
  localparam logic [SUM_W:0]     HALF_V  = (SUM_W + 1)'(N / 2);

  logic                 en_s;
  logic [N*SUM_W-1:0]   pix_sum_s;

  // Sideband travelling alongside the trees.
  logic [NLOG-1:0]      vld_d, vld_q;
  logic [NLOG-1:0]      last_d, last_q;
  logic [1:0]           mode_d [NLOG];
  logic [1:0]           mode_q [NLOG];
  logic [COLOR_W-1:0]   ctr_d [NLOG];
  logic [COLOR_W-1:0]   ctr_q [NLOG];

  logic [SUM_W-1:0]     tree_sum_s;
  logic [COLOR_W-1:0]   tree_min_s, tree_max_s;
  logic [SUM_W:0]       sum_rnd_s;
  logic [PROD_W-1:0]    prod_s;
  logic [COLOR_W-1:0]   mean_s, result_s;

  logic                 out_valid_d, out_valid_q;
  logic                 out_last_d, out_last_q;
  logic [COLOR_W-1:0]   out_data_d, out_data_q;

  // Every stage moves together; the only stall source is a held output.
  assign en_s     = ~out_valid_q | out_ready;
  assign in_ready = en_s;

  // Zero-extend each pixel to the adder-tree width.
  always_comb begin
    pix_sum_s = '0;
    for (int k = 0; k < N; k++) begin
      pix_sum_s[k*SUM_W +: SUM_W] = SUM_W'(in_data[k*COLOR_W +: COLOR_W]);
    end
  end

  for (genvar l = 0; l < NLOG; l++) begin : g_lvl
    localparam int CI = lvl_cnt(N, l);
    localparam int CO = lvl_cnt(N, l + 1);
    logic [CO*SUM_W-1:0]   sum_o;
    logic [CO*COLOR_W-1:0] min_o;
    logic [CO*COLOR_W-1:0] max_o;
    if (l == 0) begin : g_first
      reduce_stage #(.N_IN(CI), .W(COLOR_W), .SW(SUM_W)) u_stage (
        .clk   (clk),
        .en    (en_s),
        .sum_i (pix_sum_s),
        .min_i (in_data),
        .max_i (in_data),
        .sum_o (sum_o),
        .min_o (min_o),
        .max_o (max_o)
      );
    end else begin : g_next
      reduce_stage #(.N_IN(CI), .W(COLOR_W), .SW(SUM_W)) u_stage (
        .clk   (clk),
        .en    (en_s),
        .sum_i (g_lvl[l-1].sum_o),
        .min_i (g_lvl[l-1].min_o),
        .max_i (g_lvl[l-1].max_o),
        .sum_o (sum_o),
        .min_o (min_o),
        .max_o (max_o)
      );
    end
  end

  assign tree_sum_s = g_lvl[NLOG-1].sum_o;
  assign tree_min_s = g_lvl[NLOG-1].min_o;
  assign tree_max_s = g_lvl[NLOG-1].max_o;

  // Shift valid, mode, last and centre pixel one stage per advance.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    mode_d = mode_q;
    ctr_d  = ctr_q;
    if (en_s) begin
      vld_d[0]  = in_valid;
      last_d[0] = in_last;
      mode_d[0] = in_mode;
      ctr_d[0]  = in_data[CTR*COLOR_W +: COLOR_W];
      for (int i = 1; i < NLOG; i++) begin
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
        mode_d[i] = mode_q[i-1];
        ctr_d[i]  = ctr_q[i-1];
      end
    end else begin
      vld_d  = vld_q;
      last_d = last_q;
      mode_d = mode_q;
      ctr_d  = ctr_q;
    end
  end

  // Valid bits are the only sideband state that reset must clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Sideband payload registers.
  always_ff @(posedge clk) begin
    last_q <= last_d;
    mode_q <= mode_d;
    ctr_q  <= ctr_d;
  end

  // Rounded mean via reciprocal multiply (exact over the full sum range),
  // then select the result for this beat's mode.
  always_comb begin
    sum_rnd_s = (SUM_W + 1)'(tree_sum_s) + HALF_V;
    prod_s    = PROD_W'(sum_rnd_s) * PROD_W'(RECIP_V);
    mean_s    = COLOR_W'(prod_s >> FRAC);
    result_s  = ctr_q[NLOG-1];
    case (mode_q[NLOG-1])
      MODE_MEAN: result_s = mean_s;
      MODE_MIN:  result_s = tree_min_s;
      MODE_MAX:  result_s = tree_max_s;
      default:   result_s = ctr_q[NLOG-1];
    endcase
  end

  // Output stage loads on advance and holds while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (en_s) begin
      out_valid_d = vld_q[NLOG-1];
      out_data_d  = result_s;
      out_last_d  = last_q[NLOG-1];
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
    end
  end

  // Output registers, cleared by reset so nothing stale is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_window_stat_filter.sv
// Scoreboard bench for window_stat_filter: WIN=3 main instance with a
// behavioural reference, plus WIN=4 and WIN=5 instances for sizing cases.
module tb_window_stat_filter;

  localparam int WIN = 3;
  localparam int N   = WIN * WIN;
  localparam int CW  = 8;
  localparam int L   = 5;
  localparam int DW  = N * CW;

  typedef struct {
    logic [CW-1:0] data;
    logic          last;
    int            acc;
    bit            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid, out_ready, out_last;
  logic [CW-1:0] out_data;

  logic          a_valid;
  logic [199:0]  a_data;
  logic [1:0]    a_mode;
  logic          a4_in_ready, a4_ov, a4_ol;
  logic          a5_in_ready, a5_ov, a5_ol;
  logic [CW-1:0] a4_od, a5_od;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_force = 1'b1;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  window_stat_filter #(.WIN(3), .COLOR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last));

  window_stat_filter #(.WIN(4), .COLOR_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a4_in_ready),
    .in_data(a_data[127:0]), .in_mode(a_mode), .in_last(1'b0),
    .out_valid(a4_ov), .out_ready(1'b1), .out_data(a4_od), .out_last(a4_ol));

  window_stat_filter #(.WIN(5), .COLOR_W(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a5_in_ready),
    .in_data(a_data[199:0]), .in_mode(a_mode), .in_last(1'b0),
    .out_valid(a5_ov), .out_ready(1'b1), .out_data(a5_od), .out_last(a5_ol));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: rounded mean by integer division, plain min/max scan, centre pick.
  function automatic logic [CW-1:0] model(input logic [DW-1:0] d, input logic [1:0] m);
    int s, mn, mx, p, c;
    s = 0; mn = 255; mx = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(d[k*CW +: CW]);
      s += p;
      if (p < mn) mn = p;
      if (p > mx) mx = p;
    end
    c = (WIN / 2) * WIN + WIN / 2;
    case (m)
      2'd0:    return CW'((s + N / 2) / N);
      2'd1:    return CW'(mn);
      2'd2:    return CW'(mx);
      default: return d[c*CW +: CW];
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_win();
    logic [DW-1:0] d;
    int r;
    for (int k = 0; k < N; k++) begin
      r = $urandom_range(0, 5);
      d[k*CW +: CW] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    end
    return d;
  endfunction

  // Present one beat, push its expectation at the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic l,
                      input logic [CW-1:0] e, input bit lat);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_last = l;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{data: e, last: l, acc: cyc, lat: lat});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int maxc);
    for (int t = 0; t < maxc && sb_q.size() != 0; t++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_empty", sb_q.size(), 32'd0);
  endtask

  task automatic alt_run(input logic [1:0] m, input bit ramp, input int e4, input int e5);
    bit g4, g5;
    g4 = 1'b0; g5 = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) a_data[k*8 +: 8] = ramp ? 8'(k) : 8'd200;
    a_mode = m; a_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) chk("alt_in_ready", {a4_in_ready, a5_in_ready}, 32'd3);
      if (a4_ov) begin
        chk("w4_latency", n, 32'd5); chk("w4_data", a4_od, e4); g4 = 1'b1;
      end
      if (a5_ov) begin
        chk("w5_latency", n, 32'd6); chk("w5_data", a5_od, e5); g5 = 1'b1;
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
    end
    chk("w4_seen", 32'(g4), 32'd1);
    chk("w5_seen", 32'(g5), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Monitor: compare presented output against scoreboard head, pop on transfer.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q[0];
          chk("out_data", out_data, e.data);
          chk("out_last", 32'(out_last), 32'(e.last));
          if (out_ready) begin
            if (e.lat) chk("latency", cyc - e.acc, L);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [1:0] m;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; in_last = 1'b0;
    a_valid = 1'b0; a_data = '0; a_mode = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;

    // Ramp 0..8 through all four modes back to back.
    for (int k = 0; k < N; k++) d[k*CW +: CW] = 8'(k);
    send(d, 2'd0, 1'b0, 8'd4, 1'b1);
    send(d, 2'd1, 1'b0, 8'd0, 1'b1);
    send(d, 2'd2, 1'b0, 8'd8, 1'b1);
    send(d, 2'd3, 1'b1, 8'd4, 1'b1);
    for (int k = 0; k < N; k++) d[k*CW +: CW] = 8'd255;
    send(d, 2'd0, 1'b0, 8'd255, 1'b1);
    for (int k = 0; k < N; k++) d[k*CW +: CW] = 8'd1;
    d[8*CW +: CW] = 8'd5;
    send(d, 2'd0, 1'b0, 8'd1, 1'b1);
    d[8*CW +: CW] = 8'd6;
    send(d, 2'd0, 1'b0, 8'd2, 1'b1);
    drain(50);

    // Alternating valid: every output must appear exactly L cycles later.
    for (int i = 0; i < 12; i++) begin
      d = rand_win(); m = 2'($urandom_range(0, 3));
      send(d, m, 1'b0, model(d, m), 1'b1);
      @(posedge clk); #1;
    end
    drain(50);

    // Ten-beat burst with a three-cycle downstream stall.
    fork
      for (int i = 0; i < 10; i++) begin
        d = rand_win(); m = 2'($urandom_range(0, 3));
        send(d, m, (i == 9), model(d, m), 1'b0);
      end
      begin
        repeat (7) @(posedge clk);
        rdy_force = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk);
        end
        rdy_force = 1'b1;
      end
    join
    drain(50);

    // Reset with three beats in flight: nothing of them may emerge.
    for (int i = 0; i < 3; i++) begin
      d = rand_win();
      send(d, 2'd0, 1'b0, model(d, 2'd0), 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", out_data, 32'd0);
    chk("rst_mid_last", 32'(out_last), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    d = rand_win();
    send(d, 2'd2, 1'b1, model(d, 2'd2), 1'b1);
    drain(50);

    // Random sweep with random gaps and random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d = rand_win(); m = 2'($urandom_range(0, 3));
      send(d, m, 1'($urandom_range(0, 1)), model(d, m), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain(500);
    rdy_rand = 1'b0;
    rdy_force = 1'b1;

    // Other window sizes.
    alt_run(2'd0, 1'b0, 200, 200);
    alt_run(2'd0, 1'b1, 8, 12);
    alt_run(2'd3, 1'b1, 10, 12);
    alt_run(2'd1, 1'b1, 0, 0);
    alt_run(2'd2, 1'b1, 15, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_stat_filter.md
Name: window_stat_filter

Overview:
- Parametrised successor to the fixed 3x3 mean stage in the plate-recognition pixel pipeline.
- Reduces one WIN x WIN pixel window per beat to a single output pixel.
- Output is one of: rounded exact mean, minimum, maximum, or centre-pixel bypass. The operation is selected per beat.
- Fully pipelined, one window per clock, valid/ready handshake with backpressure, frame-end tag carried through. Sits between the window generator and the binarisation/edge stages.

Parameters:
- WIN, 3, window side length; legal range 2..15; N = WIN*WIN.
- COLOR_W, 8, bits per pixel; legal range 1..16.
- NLOG, ceil(log2(N)), derived: number of reduction-tree stages; 4 for WIN=3.
- SUM_W, COLOR_W+NLOG, derived: adder-tree width; no overflow possible.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  window beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  COLOR_W*N  packed window; pixel k at bits [(k+1)*COLOR_W-1 : k*COLOR_W], row-major; centre pixel k = N/2 for odd WIN, (WIN/2)*WIN+WIN/2 for even WIN.
- in_mode  in  2  per-beat op: 0 mean, 1 min, 2 max, 3 centre bypass.
- in_last  in  1  last window of frame; carried with the beat.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  COLOR_W  filtered pixel.
- out_last  out  1  in_last of the beat that produced this result.

Behaviour:
- Reset (rst=1 at a clock edge): all pipeline valid bits clear. out_valid=0, out_data=0, out_last=0 from the next cycle. Data registers need not be cleared. Reset mid-stream discards all in-flight beats, with no partial output afterwards.
- Transfer occurs on a clock edge where valid and ready are both 1, on either side.
- Pipeline advance enable: en = ~out_valid | out_ready. in_ready = en (combinational). No beat is dropped or duplicated under any out_ready pattern.
- Latency L = NLOG+1 cycles from input transfer to out_valid, when unstalled. L=5 for WIN=3. Throughput is 1 beat per clock.
- Stage 0..NLOG-1: three parallel pairwise trees (sum, min, max) over N inputs.
  - Odd element count at a level: the last element passes through registered.
  - Sum tree is SUM_W wide and unsigned.
  - mode, last and centre pixel are delayed alongside the trees.
- Final stage: select by the delayed mode.
  - mode 0: out = floor((sum + floor(N/2)) / N), i.e. round-half-up. Must be exact for every sum in 0..N*(2^COLOR_W-1).
    - Implement as ((sum + floor(N/2)) * RECIP) >> FRAC, with FRAC = SUM_W+1+NLOG and RECIP = ceil(2^FRAC/N).
    - Power-of-two N may use a shift instead.
    - Result is ≤ 2^COLOR_W-1; no saturation needed.
  - mode 1 / mode 2: tree min / max.
  - mode 3: centre pixel unchanged.
- Mode is sampled per beat. Changing in_mode on consecutive beats yields per-beat correct results with no bubble.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.
- in_data, in_mode and in_last are don't-care when in_valid=0. The pipeline may advance bubbles.

Decomposition:
- Package window_filter_pkg holds:
  - mode encodings MODE_MEAN=0, MODE_MIN=1, MODE_MAX=2, MODE_CENTRE=3;
  - constant functions clog2(n) and recip(n, frac);
  - centre_index(win).
- One sub-module, reduce_stage: a single registered tree level, parametrised by input count and width. It outputs ceil(n/2) sum/min/max results, passes any odd element through, and takes the stall enable. window_stat_filter instantiates NLOG levels plus the select/divide stage.

Test Plan (WIN=3, COLOR_W=8 unless noted):
- Pixels 0..8, modes 0/1/2/3 on four consecutive beats, out_ready=1 → out_data 4, 0, 8, 4 on cycles L..L+3, out_valid continuous.
- All pixels 255, mode 0 → 255. Eight 1s plus one 5 (sum 13), mode 0 → 1. Eight 1s plus one 6 (sum 14) → 2. Random sweep against a reference model → exact match.
- 10-beat burst with out_ready low for 3 cycles mid-burst → in_ready low for the same cycles, out_data/out_last held, all 10 results in order, out_last=1 only on result 10.
- rst pulsed 2 cycles after 3 beats accepted → out_valid=0 from the cycle after rst; no stale result afterwards; new beat emerges L cycles after its acceptance.
- WIN=4 (N=16, L=5) and WIN=5 (N=25, L=6): all pixels 200 mean → 200; pixels k=0..N-1 mean → 8 and 12 respectively; centre → pixel 10 and 12.
- in_valid toggling every other cycle, out_ready=1 → output valid pattern identical to input pattern shifted by L.
